// File: rtl/vme_seq_pkg.sv
// vme_seq_pkg: shared op codes, FSM states and command word helpers for the VME command sequencer
package vme_seq_pkg;
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_WAIT  = 2'b10,
    OP_END   = 2'b11
  } op_e;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_RSP    = 3'd4;
  localparam logic [2:0] S_PAUSE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam int CMD_RD_BIT = 25;
  localparam int CMD_WR_BIT = 24;
  localparam int REC_TMO_OFS  = 2;
  localparam int REC_MISM_OFS = 1;
  localparam int REC_RD_OFS   = 0;
  function automatic logic [31:0] cmd_word(input logic rd, input logic [15:0] a);
    cmd_word = 32'(a);
    cmd_word[CMD_RD_BIT] = rd;
    cmd_word[CMD_WR_BIT] = ~rd;
  endfunction
endpackage

// File: rtl/vme_cmd_sequencer_if.sv
// vme_cmd_sequencer_if: internal VME command/data register handshake between sequencer and slave
interface vme_cmd_sequencer_if;
  logic        vme_cmd_rd;
  logic        vme_start;
  logic [31:0] vme_cmd_reg;
  logic [31:0] vme_dat_reg_in;
  logic [31:0] vme_dat_reg_out;
  logic        vme_dat_wr;
  modport master (
    input  vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
    output vme_start, vme_cmd_reg, vme_dat_reg_in
  );
  modport slave (
    output vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
    input  vme_start, vme_cmd_reg, vme_dat_reg_in
  );
endinterface

// File: rtl/vme_seq_result_fifo.sv
// vme_seq_result_fifo: synchronous first-word-fall-through result FIFO
module vme_seq_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, count;
  logic do_push, do_pop;
  // pointer arithmetic; a push while full is accepted only alongside a pop
  always_comb begin
    count = wp_q - rp_q;
    full = count == PW'(DEPTH);
    empty = count == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wp_d = wp_q + PW'(do_push);
    rp_d = rp_q + PW'(do_pop);
    dout = mem_q[rp_q[AW-1:0]];
  end
  // pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // storage, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/vme_cmd_sequencer.sv
// vme_cmd_sequencer: replays a preloaded VME command list and logs checked results into a FIFO
module vme_cmd_sequencer
  import vme_seq_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 64,
  parameter int          RES_DEPTH = 16,
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] CMD_MASK  = 32'h00a80000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [17+2*DATA_W:0]       load_data,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       loop_mode,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                err_cnt,
  vme_cmd_sequencer_if.master        bus,
  input  logic                       res_rd,
  output logic                       res_valid,
  output logic [18+DATA_W:0]         res_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 18 + 2 * DATA_W;
  localparam int RW = 19 + DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = TW > DATA_W ? TW : DATA_W;
  logic [EW-1:0] list_q [DEPTH];
  logic [EW-1:0] ent_q;
  logic [2:0] state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] err_q, err_d;
  logic start_q, start_d;
  logic [31:0] cmd_q, cmd_d, dat_q, dat_d;
  op_e e_op;
  logic [15:0] e_addr;
  logic [DATA_W-1:0] e_data, e_mask, rd;
  logic is_read, mism, tmo, resp, err_inc, full, empty;
  logic [RW-1:0] rec;
  // entry decode, read check and result record; write records carry the written data
  always_comb begin
    e_op = op_e'(ent_q[EW-1 -: 2]);
    e_addr = ent_q[2*DATA_W +: 16];
    e_data = ent_q[DATA_W +: DATA_W];
    e_mask = ent_q[0 +: DATA_W];
    is_read = e_op == OP_READ;
    rd = bus.vme_dat_reg_out[DATA_W-1:0];
    mism = is_read && |((rd ^ e_data) & e_mask);
    tmo = cnt_q == CW'(TIMEOUT);
    resp = state_q == S_RSP && (bus.vme_dat_wr || tmo);
    err_inc = resp && (!bus.vme_dat_wr || mism);
    rec = bus.vme_dat_wr ? {1'b0, mism, is_read, e_addr, is_read ? rd : e_data}
                         : {1'b1, 1'b0, is_read, e_addr, {DATA_W{1'b0}}};
  end
  // sequencer FSM; command strobe and registers default back to their idle values every cycle
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_inc && err_q != 16'hFFFF ? err_q + 16'd1 : err_q;
    start_d = 1'b0;
    cmd_d = CMD_MASK;
    dat_d = '0;
    case (state_q)
      S_IDLE: if (start && !abort) begin
        state_d = S_FETCH;
        ptr_d = '0;
        err_d = '0;
      end
      S_FETCH: state_d = abort ? S_IDLE : S_DECODE;
      S_DECODE: if (abort) state_d = S_IDLE;
      else case (e_op)
        OP_WRITE, OP_READ: state_d = S_ISSUE;
        OP_WAIT: begin
          state_d = e_data == '0 ? S_FETCH : S_PAUSE;
          ptr_d = e_data == '0 ? ptr_q + 1'b1 : ptr_q;
          cnt_d = CW'(e_data);
        end
        OP_END: state_d = S_DONE;
      endcase
      S_ISSUE: if (abort) state_d = S_IDLE;
      else if (bus.vme_cmd_rd && !full) begin
        state_d = S_RSP;
        start_d = 1'b1;
        cmd_d = cmd_word(is_read, e_addr) | CMD_MASK;
        dat_d = is_read ? '0 : 32'(e_data);
        cnt_d = '0;
      end
      S_RSP: if (resp) begin
        state_d = abort ? S_IDLE : S_FETCH;
        ptr_d = ptr_q + 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      S_PAUSE: if (abort) state_d = S_IDLE;
      else if (cnt_q == CW'(1)) begin
        state_d = S_FETCH;
        ptr_d = ptr_q + 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      S_DONE: begin
        state_d = !abort && loop_mode ? S_FETCH : S_IDLE;
        ptr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      start_q <= 1'b0;
      cmd_q <= CMD_MASK;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      start_q <= start_d;
      cmd_q <= cmd_d;
      dat_q <= dat_d;
    end
  end
  // command list RAM, loadable only while idle, read continuously at the pointer
  always_ff @(posedge clk) begin
    if (load_en && !busy) list_q[load_addr] <= load_data;
    ent_q <= list_q[ptr_q];
  end
  vme_seq_result_fifo #(.WIDTH(RW), .DEPTH(RES_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (resp),
    .pop   (res_rd),
    .din   (rec),
    .dout  (res_data),
    .full  (full),
    .empty (empty)
  );
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign err_cnt = err_q;
  assign res_valid = !empty;
  assign bus.vme_start = start_q;
  assign bus.vme_cmd_reg = cmd_q;
  assign bus.vme_dat_reg_in = dat_q;
endmodule
